// File: rtl/fwd_scoreboard.sv
// Operand forwarding scoreboard at the ID->EX boundary: tracks in-flight writers,
// selects the youngest ready producer per source and raises the dependency stall.
module fwd_scoreboard #(
    parameter int WIDTH      = 32,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int REG_ADDR_W = 5,
    parameter int LAT_W      = 2,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold_i,
    input  logic [DEPTH-1:0]              flush_mask_i,
    input  logic                          iss_valid_i,
    input  logic                          iss_we_i,
    input  logic [REG_ADDR_W-1:0]         iss_rd_i,
    input  logic [LAT_W-1:0]              iss_lat_i,
    input  logic [NUM_SRC-1:0]            src_used_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_i,
    input  logic [NUM_SRC*WIDTH-1:0]      src_rdata_i,
    input  logic [DEPTH*WIDTH-1:0]        stage_data_i,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o,
    output logic [NUM_SRC*WIDTH-1:0]      operand_o,
    output logic                          stall_o,
    output logic                          busy_o
);

    logic [DEPTH-1:0]      vld_q, vld_d, vld_m;
    logic [REG_ADDR_W-1:0] rd_q  [DEPTH];
    logic [REG_ADDR_W-1:0] rd_d  [DEPTH];
    logic [LAT_W-1:0]      lat_q [DEPTH];
    logic [LAT_W-1:0]      lat_d [DEPTH];

    logic                  hit;
    int                    hit_k;
    logic [REG_ADDR_W-1:0] addr;

    // Latencies beyond the last position saturate so the oldest slot is always forwardable.
    function automatic logic [LAT_W-1:0] lat_clamp(input logic [LAT_W-1:0] lat);
        if (int'(lat) > DEPTH - 1) return LAT_W'(DEPTH - 1);
        return lat;
    endfunction

    always_comb begin
        stall_o   = 1'b0;
        fwd_sel_o = '0;
        operand_o = src_rdata_i;
        hit       = 1'b0;
        hit_k     = 0;
        addr      = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            addr  = src_addr_i[s*REG_ADDR_W +: REG_ADDR_W];
            hit   = 1'b0;
            hit_k = 0;
            // Scan oldest to youngest so the lowest matching position overrides.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (vld_q[k] && rd_q[k] == addr && addr != '0) begin
                    hit   = 1'b1;
                    hit_k = k;
                end
            end
            if (hit) begin
                if (hit_k >= int'(lat_q[hit_k])) begin
                    fwd_sel_o[s*SEL_W +: SEL_W] = SEL_W'(hit_k + 1);
                    operand_o[s*WIDTH +: WIDTH] = stage_data_i[hit_k*WIDTH +: WIDTH];
                end else if (iss_valid_i && src_used_i[s]) begin
                    stall_o = 1'b1;
                end
            end
        end
    end

    // Flush masks the pre-shift entries, so a same-cycle insert is never killed.
    always_comb begin
        vld_m = vld_q & ~flush_mask_i;
        vld_d = vld_m;
        rd_d  = rd_q;
        lat_d = lat_q;
        if (!hold_i) begin
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k] = vld_m[k-1];
                rd_d[k]  = rd_q[k-1];
                lat_d[k] = lat_q[k-1];
            end
            vld_d[0] = iss_valid_i & iss_we_i & ~stall_o & (iss_rd_i != '0);
            rd_d[0]  = iss_rd_i;
            lat_d[0] = lat_clamp(iss_lat_i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_q <= '0;
        else      vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
        rd_q  <= rd_d;
        lat_q <= lat_d;
    end

    assign busy_o = |vld_q;

endmodule
